video_timing_gen: RTL and testbench

- Raster timing generator that sits directly upstream of the three TMDS encoder lanes.
- Produces the DE, hsync and vsync strobes that the encoders consume as DE/C0/C1, plus the active pixel coordinates for the pixel source.
- Runs in the pixel clock domain. An optional clock-enable allows sub-rate operation.

---
 rtl/video_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for the TMDS encoder lanes.
// Produces de/hsync/vsync, active-area x/y and line/frame start pulses,
// all registered one cycle behind the h_cnt/v_cnt raster counters.
// Optional feature macro: VIDEO_TIMING_TEST_PATTERN_EN adds r/g/b outputs
// carrying eight vertical colour bars.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        line_start,
    output logic        frame_start
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    ,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
`endif
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned EXT_W   = CNT_W + 1;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Comparison bounds carry one extra bit so a 4096 bound stays representable.
    localparam logic [EXT_W-1:0] H_ACT_END = EXT_W'(H_ACTIVE);
    localparam logic [EXT_W-1:0] V_ACT_END = EXT_W'(V_ACTIVE);
    localparam logic [EXT_W-1:0] HS_BEG    = EXT_W'(H_ACTIVE + H_FP);
    localparam logic [EXT_W-1:0] HS_END    = EXT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [EXT_W-1:0] VS_BEG    = EXT_W'(V_ACTIVE + V_FP);
    localparam logic [EXT_W-1:0] VS_END    = EXT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    logic [EXT_W-1:0] h_ext_c;
    logic [EXT_W-1:0] v_ext_c;
    logic             h_last_c;
    logic             v_last_c;
    logic             de_c;
    logic             hs_c;
    logic             vs_c;

    assign h_ext_c  = EXT_W'(h_cnt);
    assign v_ext_c  = EXT_W'(v_cnt);
    assign h_last_c = (h_cnt == H_LAST);
    assign v_last_c = (v_cnt == V_LAST);
    assign de_c     = (h_ext_c < H_ACT_END) && (v_ext_c < V_ACT_END);
    assign hs_c     = (h_ext_c >= HS_BEG) && (h_ext_c < HS_END);
    assign vs_c     = (v_ext_c >= VS_BEG) && (v_ext_c < VS_END);

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce) begin
            h_cnt <= h_last_c ? '0 : h_cnt + CNT_W'(1);
            if (h_last_c) begin
                v_cnt <= v_last_c ? '0 : v_cnt + CNT_W'(1);
            end
        end
    end

    // Registered strobes and coordinates decoded from the pre-edge counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            de          <= de_c;
            hsync       <= hs_c ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_c ? VSYNC_POL : ~VSYNC_POL;
            x           <= de_c ? h_cnt : '0;
            y           <= de_c ? v_cnt : '0;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    localparam int unsigned     BAR_W    = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    logic [2:0]       bar_cnt;
    logic [CNT_W-1:0] pix_cnt;
    logic [23:0]      colour_c;

    // Bar tracker follows h_cnt without a divider; the last bar keeps counting
    // so it absorbs any remainder of the active width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_cnt <= '0;
            pix_cnt <= '0;
        end else if (ce) begin
            if (h_last_c) begin
                bar_cnt <= '0;
                pix_cnt <= '0;
            end else if ((pix_cnt == BAR_LAST) && (bar_cnt != 3'd7)) begin
                bar_cnt <= bar_cnt + 3'd1;
                pix_cnt <= '0;
            end else begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
        end
    end

    // Bar index to RGB colour.
    always_comb begin
        colour_c = 24'h000000;
        case (bar_cnt)
            3'd0:    colour_c = 24'hFFFFFF;
            3'd1:    colour_c = 24'hFFFF00;
            3'd2:    colour_c = 24'h00FFFF;
            3'd3:    colour_c = 24'h00FF00;
            3'd4:    colour_c = 24'hFF00FF;
            3'd5:    colour_c = 24'hFF0000;
            3'd6:    colour_c = 24'h0000FF;
            default: colour_c = 24'h000000;
        endcase
    end

    // Colour outputs registered alongside de/x/y, blanked outside the active area.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else if (ce) begin
            r <= de_c ? colour_c[23:16] : 8'h00;
            g <= de_c ? colour_c[15:8]  : 8'h00;
            b <= de_c ? colour_c[7:0]   : 8'h00;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen with a small 16x8 raster; an arithmetic
// raster model is compared against the DUT on every falling clock edge.
module tb_video_timing_gen;

    localparam int H_A = 8, H_F = 2, H_S = 3, H_B = 3;
    localparam int V_A = 4, V_F = 1, V_S = 2, V_B = 1;
    localparam int HT  = H_A + H_F + H_S + H_B;
    localparam int VT  = V_A + V_F + V_S + V_B;
    localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        ce    = 1'b1;
    logic        de, hsync, vsync, line_start, frame_start;
    logic [11:0] x, y;
    logic [23:0] rgb_c;

    int checks = 0;
    int errors = 0;
    int n_en   = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    logic [7:0] r, g, b;
    logic [7:0] r2, g2, b2;
    logic       de2, hs2, vs2, ls2, fs2;
    logic [11:0] x2, y2;
    assign rgb_c = {r, g, b};

    video_timing_gen dut (
        .clk(clk), .reset(reset), .ce(ce), .de(de), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
        .r(r), .g(g), .b(b)
    );
    defparam dut.H_ACTIVE = H_A;
    defparam dut.H_FP = H_F;
    defparam dut.H_SYNC = H_S;
    defparam dut.H_BP = H_B;
    defparam dut.V_ACTIVE = V_A;
    defparam dut.V_FP = V_F;
    defparam dut.V_SYNC = V_S;
    defparam dut.V_BP = V_B;

    video_timing_gen dut2 (
        .clk(clk), .reset(reset), .ce(ce), .de(de2), .hsync(hs2), .vsync(vs2),
        .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2),
        .r(r2), .g(g2), .b(b2)
    );
`else
    assign rgb_c = 24'h000000;

    video_timing_gen #(
        .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
        .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .de(de), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
    );
`endif

    // Count of enabled clock edges since the last reset.
    always @(posedge clk or posedge reset) begin
        if (reset) n_en <= 0;
        else if (ce) n_en <= n_en + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs after n enabled edges: {ls, fs, de, hsync, vsync, x, y, rgb}.
    function automatic logic [52:0] model(input int n);
        int p, h, v, bw, bar;
        logic d, hs, vs;
        logic [23:0] c;
        if (n == 0) return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 24'd0};
        p   = (n - 1) % (HT * VT);
        h   = p % HT;
        v   = p / HT;
        d   = (h < H_A) && (v < V_A);
        hs  = !((h >= H_A + H_F) && (h < H_A + H_F + H_S));
        vs  = !((v >= V_A + V_F) && (v < V_A + V_F + V_S));
        bw  = H_A / 8;
        bar = h / bw;
        if (bar > 7) bar = 7;
        c   = (PAT && d) ? BARS[bar] : 24'h000000;
        return {(h == 0), (p == 0), d, hs, vs,
                d ? 12'(h) : 12'd0, d ? 12'(v) : 12'd0, c};
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [52:0] e, a;
        e = model(n_en);
        a = {line_start, frame_start, de, hsync, vsync, x, y, rgb_c};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL model n=%0d actual=%h expected=%h", n_en, a, e);
        end
    end

    // Rising-edge period tracking of frame_start and line_start.
    int fs_last = 0, ls_last = 0, fs_period = 0, ls_period = 0;
    bit fs_prev = 1'b0, ls_prev = 1'b0, fs_seen = 1'b0, ls_seen = 1'b0;
    always @(negedge clk) begin
        if (frame_start && !fs_prev) begin
            if (fs_seen) fs_period = cyc - fs_last;
            fs_last = cyc;
            fs_seen = 1'b1;
        end
        if (line_start && !ls_prev) begin
            if (ls_seen) ls_period = cyc - ls_last;
            ls_last = cyc;
            ls_seen = 1'b1;
        end
        fs_prev = frame_start;
        ls_prev = line_start;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_first_edge(input string tag);
        chk({tag, "_de"}, 32'(de), 32'd1);
        chk({tag, "_x"}, 32'(x), 32'd0);
        chk({tag, "_y"}, 32'(y), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd1);
        chk({tag, "_ls"}, 32'(line_start), 32'd1);
    endtask

    initial begin
        int de_cnt, de_late, hs_lo, vs_lo, ls_cnt, fs_cnt, hs_first, vs_first;
        bit found;

        // Reset held with ce=1.
        repeat (3) @(negedge clk);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        reset = 1'b0;

        // One full frame window starting at the first enabled edge.
        de_cnt = 0; de_late = 0; hs_lo = 0; vs_lo = 0; ls_cnt = 0; fs_cnt = 0;
        hs_first = -1; vs_first = -1;
        for (int i = 0; i < HT * VT; i++) begin
            @(negedge clk);
            if (i == 0) chk_first_edge("first");
            de_cnt += int'(de);
            if (de && (i / HT) >= V_A) de_late++;
            if (!hsync) begin hs_lo++; if (hs_first < 0) hs_first = i; end
            if (!vsync) begin vs_lo++; if (vs_first < 0) vs_first = i; end
            ls_cnt += int'(line_start);
            fs_cnt += int'(frame_start);
        end
        chk("de_cycles", 32'(de_cnt), 32'd32);
        chk("de_blank_lines", 32'(de_late), 32'd0);
        chk("hsync_low_cycles", 32'(hs_lo), 32'd24);
        chk("hsync_first_low", 32'(hs_first), 32'd10);
        chk("vsync_low_cycles", 32'(vs_lo), 32'd32);
        chk("vsync_first_low", 32'(vs_first), 32'd80);
        chk("line_pulses", 32'(ls_cnt), 32'd8);
        chk("frame_pulses", 32'(fs_cnt), 32'd1);

        repeat (HT * VT) @(negedge clk);
        #1;
        chk("frame_period", 32'(fs_period), 32'd128);
        chk("line_period", 32'(ls_period), 32'd16);

        // ce at 1/3 duty.
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            ce = (k % 3 == 0);
        end
        @(negedge clk);
        ce = 1'b1;
        #1;
        chk("ce_frame_period", 32'(fs_period), 32'd384);

        // Async reset when the counters sit at v=2, h=5.
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (n_en % (HT * VT) == 2 * HT + 5) found = 1'b1;
        end
        chk("midreset_reached", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_de", 32'(de), 32'd0);
        chk("async_hsync", 32'(hsync), 32'd1);
        chk("async_vsync", 32'(vsync), 32'd1);
        chk("async_x", 32'(x), 32'd0);
        chk("async_y", 32'(y), 32'd0);
        chk("async_ls", 32'(line_start), 32'd0);
        chk("async_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_first_edge("post_reset");
        repeat (HT * VT + 2) @(negedge clk);
        #1;
        chk("post_reset_period", 32'(fs_period), 32'd128);

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        // Default 640x480 instance: colour bars along the first line.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 720; i++) begin
            @(negedge clk);
            if (i == 1)   chk("pat_x0", 32'({r2, g2, b2}), 32'hFFFFFF);
            if (i == 81)  chk("pat_x80", 32'({r2, g2, b2}), 32'hFFFF00);
            if (i == 81)  chk("pat_x80_pos", 32'(x2), 32'd80);
            if (i == 640) chk("pat_x639", 32'({r2, g2, b2}), 32'h000000);
            if (i == 640) chk("pat_x639_de", 32'(de2), 32'd1);
            if (i == 700) chk("pat_blank", 32'({r2, g2, b2}), 32'h000000);
            if (i == 700) chk("pat_blank_de", 32'(de2), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
